// File: rtl/mm_sched_pkg.sv
// Shared types and constants for the 2x2 tile scheduler and its result buffer.
package mm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    COMPUTE,
    DRAIN,
    DONE
  } state_e;

  localparam int NUM_SLOTS    = 4;
  localparam int SLOT_C11     = 0;
  localparam int SLOT_C12     = 1;
  localparam int SLOT_C21     = 2;
  localparam int SLOT_C22     = 3;
  localparam int RESULT_BYTES = 4;
  localparam int TILE_BYTES   = 16;
  localparam int RESULT_SHIFT = $clog2(RESULT_BYTES);
  localparam int TILE_SHIFT   = $clog2(TILE_BYTES);

endpackage

// File: rtl/mm_result_buffer.sv
// Four-slot capture buffer for one tile's results, drained strictly in slot order
// through a registered valid/ready port.
module mm_result_buffer
  import mm_sched_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [NUM_SLOTS-1:0] cap_en,
  input  logic [DATA_W-1:0]    cap_data [NUM_SLOTS],
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [1:0]           out_slot,
  output logic                 all_written
);

  logic [DATA_W-1:0]    slot_q [NUM_SLOTS];
  logic [DATA_W-1:0]    slot_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] filled_q, filled_d;
  logic [2:0]           rd_ptr_q, rd_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;

  always_comb begin
    slot_d      = slot_q;
    filled_d    = filled_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clear) begin
      filled_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cap_en[i]) begin
          slot_d[i]   = cap_data[i];
          filled_d[i] = 1'b1;
        end
      end
      // A slot is presented only once the previous one has been handed off.
      if (out_valid_q) begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rd_ptr_d    = rd_ptr_q + 3'd1;
        end
      end else if (!rd_ptr_q[2] && filled_q[rd_ptr_q[1:0]]) begin
        out_valid_d = 1'b1;
        out_data_d  = slot_q[rd_ptr_q[1:0]];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    always_ff @(posedge clk or posedge reset) begin
      if (reset) slot_q[gi] <= '0;
      else       slot_q[gi] <= slot_d[gi];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filled_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      filled_q    <= filled_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_slot    = rd_ptr_q[1:0];
  assign all_written = rd_ptr_q[2];

endmodule

// File: rtl/mm_tile_scheduler.sv
// Job sequencer for the 2x2 matrix-multiplier core: one start pulse per tile, results
// captured and written out in order. Define MM_TILE_SCHED_PERF_EN for the perf_cycles counter.
module mm_tile_scheduler
  import mm_sched_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TILE_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [16:0]       cmd_size,
  input  logic [TILE_W-1:0] cmd_tiles,
  input  logic [ADDR_W-1:0] cmd_dst_addr,
  output logic              core_start,
  output logic [16:0]       core_size,
  input  logic              core_c11ready,
  input  logic              core_c12ready,
  input  logic              core_c21ready,
  input  logic              core_c22ready,
  input  logic [DATA_W-1:0] core_C11,
  input  logic [DATA_W-1:0] core_C12,
  input  logic [DATA_W-1:0] core_C21,
  input  logic [DATA_W-1:0] core_C22,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TILE_W-1:0] tiles_done
`ifdef MM_TILE_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [16:0]       size_q, size_d;
  logic [TILE_W-1:0] tiles_q, tiles_d;
  logic [TILE_W-1:0] tiles_done_q, tiles_done_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              core_start_q, core_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic                 accept, timeout, all_written;
  logic [1:0]           wr_slot;
  logic [NUM_SLOTS-1:0] cap_en;
  logic [DATA_W-1:0]    cap_data [NUM_SLOTS];

  assign accept  = cmd_valid && (state_q == IDLE);
  // The watchdog counts cycles since core_start; a c22 on the last allowed cycle still wins.
  assign timeout = (state_q == COMPUTE) && !core_c22ready &&
                   (wdog_q >= WD_W'(TIMEOUT_CYCLES - 1));

  assign cap_en = {core_c22ready, core_c21ready, core_c12ready, core_c11ready} &
                  {NUM_SLOTS{state_q == COMPUTE}};
  assign cap_data[SLOT_C11] = core_C11;
  assign cap_data[SLOT_C12] = core_C12;
  assign cap_data[SLOT_C21] = core_C21;
  assign cap_data[SLOT_C22] = core_C22;

  mm_result_buffer #(.DATA_W(DATA_W)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .clear       ((state_q == START) || timeout),
    .cap_en      (cap_en),
    .cap_data    (cap_data),
    .out_ready   (wr_ready),
    .out_valid   (wr_valid),
    .out_data    (wr_data),
    .out_slot    (wr_slot),
    .all_written (all_written)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    tiles_d      = tiles_q;
    tiles_done_d = tiles_done_q;
    base_d       = base_q;
    wdog_d       = wdog_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          size_d       = cmd_size;
          tiles_d      = cmd_tiles;
          base_d       = cmd_dst_addr;
          tiles_done_d = '0;
          err_d        = 1'b0;
          if ($signed(cmd_size) <= 0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (cmd_tiles == '0) begin
            state_d = DONE;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        wdog_d  = WD_W'(1);
        state_d = COMPUTE;
      end
      COMPUTE: begin
        if (core_c22ready) begin
          state_d = DRAIN;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      DRAIN: begin
        if (all_written) begin
          tiles_done_d = tiles_done_q + TILE_W'(1);
          if (({1'b0, tiles_done_q} + (TILE_W + 1)'(1)) < {1'b0, tiles_q}) state_d = START;
          else                                                              state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    core_start_d = (state_d == START);
    busy_d       = (state_d == START) || (state_d == COMPUTE) || (state_d == DRAIN);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      size_q       <= '0;
      tiles_q      <= '0;
      tiles_done_q <= '0;
      base_q       <= '0;
      wdog_q       <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      tiles_q      <= tiles_d;
      tiles_done_q <= tiles_done_d;
      base_q       <= base_d;
      wdog_q       <= wdog_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign core_start = core_start_q;
  assign core_size  = size_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign tiles_done = tiles_done_q;
  assign wr_addr    = base_q + (ADDR_W'(tiles_done_q) << TILE_SHIFT) +
                      (ADDR_W'(wr_slot) << RESULT_SHIFT);

`ifdef MM_TILE_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept)                      perf_d = '0;
    else if (busy_q && perf_q != '1) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
